// File: rtl/rot_quad_gen_if.sv
// ----------------------------------------------------------------------------
// rot_quad_gen_if
//   Command handshake for the rotary-encoder emulator.
//
//   cmd_valid  master -> slave  command present
//   cmd_dir    master -> slave  1 = clockwise, 0 = counter-clockwise
//   cmd_count  master -> slave  detents to emit, 0..15
//   cmd_ready  slave  -> master emulator idle, command will be taken
//
//   A command transfers on the rising clock edge where cmd_valid and
//   cmd_ready are both high.
// ----------------------------------------------------------------------------
interface rot_quad_gen_if;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [3:0] cmd_count;
    logic       cmd_ready;

    // Command source (bench, self-test controller).
    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_count,
        input  cmd_ready
    );

    // The emulator itself.
    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/rot_quad_gen.sv
// ----------------------------------------------------------------------------
// rot_quad_gen
//   Quadrature-encoder emulator: behaves like the transmitter end of a
//   mechanical rotary encoder. Each accepted command emits cmd_count detents
//   in the requested direction on rot_a/rot_b, holding every quadrature state
//   for DWELL clock cycles, and keeps a signed detent position count.
//
//   Parameters
//     DWELL  clock cycles each quadrature state is held (>= 1)
//     CNT_W  width of the position counter
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     cmd    command handshake (slave side of rot_quad_gen_if)
//     rot_a  quadrature channel A, registered
//     rot_b  quadrature channel B, registered
//     done   one-cycle pulse when a command has finished
//     pos    two's-complement detent position, wraps modulo 2^CNT_W
//
//   Sequences as (A,B), starting from the rest state 11:
//     CW : 01, 00, 10, 11
//     CCW: 10, 00, 01, 11
//
//   Detent timing (DWELL=4, one detent): the state after the accepting edge
//   shows 01; cycles 1-4 are 01, 5-8 are 00, 9-12 are 10, 13-16 are 11.
//   The FSM drops back to IDLE at the edge that starts cycle 16, so that the
//   final rest cycle is the one where done is high, cmd_ready is high and
//   pos already includes the finished detent. A command offered in that
//   cycle is taken at its closing edge, which keeps back-to-back commands
//   free of any rest gap beyond the normal DWELL-cycle 11 hold.
// ----------------------------------------------------------------------------
module rot_quad_gen #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rot_quad_gen_if.slave    cmd,
    output logic             rot_a,
    output logic             rot_b,
    output logic             done,
    output logic [CNT_W-1:0] pos
);

    // Dwell counter width; a 1-bit counter is kept even for DWELL=1.
    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DWELL_ONE  = DW_W'(1);
    localparam bit              SINGLE     = (DWELL == 1);

    localparam logic [1:0] REST = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg,     state_next;
    logic [1:0]       phase_reg,     phase_next;
    logic [DW_W-1:0]  dwell_reg,     dwell_next;
    logic [3:0]       remaining_reg, remaining_next;
    logic             dir_reg,       dir_next;
    logic [CNT_W-1:0] pos_reg,       pos_next;
    logic [1:0]       rot_reg,       rot_next;   // {A,B}
    logic             done_reg,      done_next;

    logic             accept;
    logic             detent_end;

    // ------------------------------------------------------------------
    // Quadrature code for a given phase. The CCW sequence is the CW one
    // with the two channels swapped, which keeps both Gray-coded.
    // ------------------------------------------------------------------
    function automatic logic [1:0] quad_code(input logic dir,
                                             input logic [1:0] phase);
        logic [1:0] cw;
        case (phase)
            2'd0:    cw = 2'b01;
            2'd1:    cw = 2'b00;
            2'd2:    cw = 2'b10;
            default: cw = 2'b11;
        endcase
        quad_code = dir ? cw : {cw[0], cw[1]};
    endfunction

    assign accept = (state_reg == IDLE) && cmd.cmd_valid;

    // The edge that makes the last cycle of the closing 11 state current.
    // With DWELL=1 that last cycle is also the first 11 cycle, so the
    // detent completes on the 10 -> 11 step itself.
    assign detent_end = (state_reg == RUN) &&
                        (SINGLE ? ((phase_reg == 2'd2) && (dwell_reg == '0))
                                : ((phase_reg == 2'd3) && (dwell_reg == DWELL_ONE)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            phase_reg     <= 2'd0;
            dwell_reg     <= '0;
            remaining_reg <= 4'd0;
            dir_reg       <= 1'b0;
            pos_reg       <= '0;
            rot_reg       <= REST;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            dwell_reg     <= dwell_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            pos_reg       <= pos_next;
            rot_reg       <= rot_next;
            done_reg      <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        dwell_next     = dwell_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        pos_next       = pos_reg;
        rot_next       = rot_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                // A zero-detent command completes the handshake and is
                // otherwise a no-op: no output activity and no done.
                if (accept && (cmd.cmd_count != 4'd0)) begin
                    state_next     = RUN;
                    remaining_next = cmd.cmd_count;
                    dir_next       = cmd.cmd_dir;
                    phase_next     = 2'd0;
                    dwell_next     = DWELL_LAST;
                    rot_next       = quad_code(cmd.cmd_dir, 2'd0);
                end
            end

            RUN: begin
                if (dwell_reg != '0) begin
                    dwell_next = dwell_reg - DWELL_ONE;
                end else if (phase_reg != 2'd3) begin
                    phase_next = phase_reg + 2'd1;
                    dwell_next = DWELL_LAST;
                    rot_next   = quad_code(dir_reg, phase_reg + 2'd1);
                end else begin
                    // Rest state fully held and more detents to go.
                    phase_next = 2'd0;
                    dwell_next = DWELL_LAST;
                    rot_next   = quad_code(dir_reg, 2'd0);
                end

                if (detent_end) begin
                    pos_next       = dir_reg ? (pos_reg + CNT_W'(1))
                                             : (pos_reg - CNT_W'(1));
                    remaining_next = remaining_reg - 4'd1;
                    if (remaining_reg == 4'd1) begin
                        // Outputs already sit at 11 and stay there in IDLE.
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                rot_next   = REST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers.
    // ------------------------------------------------------------------
    assign cmd.cmd_ready = (state_reg == IDLE);
    assign rot_a         = rot_reg[1];
    assign rot_b         = rot_reg[0];
    assign done          = done_reg;
    assign pos           = pos_reg;

endmodule

// File: tb/tb_rot_quad_gen.sv
// ----------------------------------------------------------------------------
// tb_rot_quad_gen
//   Scoreboard bench for rot_quad_gen. The driver pushes the expected (A,B)
//   waveform and final position for every accepted command; a monitor pops
//   one waveform sample per busy cycle and one position per done pulse.
// ----------------------------------------------------------------------------
module tb_rot_quad_gen;

    localparam int DWELL  = 4;
    localparam int CNT_W  = 8;
    localparam int BUDGET = 4 * DWELL * 16 + 20;

    logic             clk;
    logic             rst_n;
    logic             rot_a;
    logic             rot_b;
    logic             done;
    logic [CNT_W-1:0] pos;

    rot_quad_gen_if cmd_if ();

    rot_quad_gen #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd_if),
        .rot_a (rot_a),
        .rot_b (rot_b),
        .done  (done),
        .pos   (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder behaviour: sequence of (A,B) codes for one detent.
    logic [1:0] cw_seq  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] ccw_seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    logic [1:0] rot_q [$];
    int         pos_q [$];
    int         model_pos;
    int         chk_cnt;
    int         pass_cnt;
    logic       last_accept_done;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: an encoder turned n detents, each detent four codes
    // held DWELL cycles apiece, position moving by one per detent.
    task automatic model_push(input bit dir, input int n);
        for (int d = 0; d < n; d++) begin
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < DWELL; k++)
                    rot_q.push_back(dir ? cw_seq[p] : ccw_seq[p]);
            model_pos = dir ? (model_pos + 1) % 256 : (model_pos + 255) % 256;
        end
        if (n != 0) pos_q.push_back(model_pos);
    endtask

    // Offer a command, wait (bounded) for it to be taken, then scramble the
    // command fields. hold>0 keeps cmd_valid high with junk for hold-1 busy
    // cycles, which the block must ignore.
    task automatic send(input bit dir, input int n, input int hold);
        int t;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_count = 4'(n);
        t = 0;
        while (!cmd_if.cmd_ready && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_if.cmd_ready) begin
            fail_now("accept_timeout");
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        last_accept_done = done;
        @(posedge clk);
        model_push(dir, n);
        $display("cmd dir=%0d count=%0d accepted at %0t", dir, n, $time);
        #1;
        cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
        cmd_if.cmd_count = 4'($urandom_range(0, 15));
        cmd_if.cmd_valid = (hold > 0) && (n != 0);
        if (hold > 0 && n != 0) begin
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
                cmd_if.cmd_count = 4'($urandom_range(1, 15));
            end
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((!cmd_if.cmd_ready || rot_q.size() != 0) && t < BUDGET * 2) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_if.cmd_ready || rot_q.size() != 0) fail_now("idle_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rot"},   {30'd0, rot_a, rot_b}, 32'd3);
        check({tag, "_pos"},   {24'd0, pos},          32'd0);
        check({tag, "_ready"}, {31'd0, cmd_if.cmd_ready}, 32'd1);
        check({tag, "_done"},  {31'd0, done},         32'd0);
    endtask

    // Monitor: one expected code per busy cycle (including the done cycle),
    // rest state otherwise; one expected position per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!cmd_if.cmd_ready || done) begin
                if (rot_q.size() == 0) fail_now("rot_unexpected_activity");
                else check("rot_ab", {30'd0, rot_a, rot_b},
                           {30'd0, rot_q.pop_front()});
            end else begin
                check("rot_idle_rest", {30'd0, rot_a, rot_b}, 32'd3);
            end
            if (done) begin
                if (pos_q.size() == 0) fail_now("done_unexpected");
                else begin
                    int ep;
                    ep = pos_q.pop_front();
                    check("pos_at_done", {24'd0, pos}, 32'(ep));
                    $display("done pos=0x%0h at %0t", pos, $time);
                end
            end
        end
    end

    initial begin
        chk_cnt          = 0;
        pass_cnt         = 0;
        model_pos        = 0;
        last_accept_done = 1'b0;
        rst_n            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_count = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // CW single detent, then CCW triple from pos=1.
        send(1'b1, 1, 0);
        wait_idle();
        check("pos_after_cw1", {24'd0, pos}, 32'd1);
        send(1'b0, 3, 0);
        wait_idle();
        check("pos_after_ccw3", {24'd0, pos}, 32'hFE);

        // Zero-count command: accepted, nothing happens.
        send(1'b1, 0, 0);
        @(negedge clk);
        check("zero_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("zero_done",  {31'd0, done}, 32'd0);
        check("zero_pos",   {24'd0, pos}, 32'(model_pos));

        // cmd_valid held high with junk during RUN.
        send(1'b1, 2, 4 * DWELL * 2 - 1);
        wait_idle();

        // Back-to-back: second command taken in the done cycle.
        send(1'b0, 2, 0);
        send(1'b1, 1, 0);
        check("b2b_accept_on_done", {31'd0, last_accept_done}, 32'd1);
        wait_idle();

        // Asynchronous reset mid-idle with a non-zero position.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("idle_reset");
        model_pos = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized commands with random gaps and junk during RUN.
        for (int i = 0; i < 20; i++) begin
            bit dir;
            int n;
            int hold;
            dir  = 1'($urandom_range(0, 1));
            n    = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            hold = (n > 0 && $urandom_range(0, 1) == 1)
                   ? int'($urandom_range(1, 4 * DWELL * n - 1)) : 0;
            send(dir, n, hold);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Wrap: 255 CW detents from 0, then one more CW, then one CCW.
        @(posedge clk);
        #2 rst_n = 1'b0;
        rot_q.delete();
        pos_q.delete();
        model_pos = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 17; i++) send(1'b1, 15, 0);
        wait_idle();
        check("wrap_preset_ff", {24'd0, pos}, 32'hFF);
        send(1'b1, 1, 0);
        wait_idle();
        check("wrap_cw_to_00", {24'd0, pos}, 32'h00);
        send(1'b0, 1, 0);
        wait_idle();
        check("wrap_ccw_to_ff", {24'd0, pos}, 32'hFF);

        // Abort during the 00 state of the second detent of five.
        send(1'b1, 5, 0);
        repeat (4 * DWELL + DWELL + 2) @(negedge clk);
        check("abort_in_00", {30'd0, rot_a, rot_b}, 32'd0);
        #2 rst_n = 1'b0;
        rot_q.delete();
        pos_q.delete();
        model_pos = 0;
        #1 check_reset_outputs("abort");
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(1'b1, 2, 0);
        wait_idle();
        check("after_abort_pos", {24'd0, pos}, 32'd2);

        repeat (3) @(negedge clk);
        check("rot_queue_drained", 32'(rot_q.size()), 32'd0);
        check("pos_queue_drained", 32'(pos_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
